// File: rtl/regalu_seq_pkg.sv
// Shared types and instruction-field layout for the register/ALU sequencer.
package regalu_seq_pkg;

  localparam int OP_W  = 3;
  localparam int REG_W = 4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int WEN_BIT = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/regalu_seq_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the requester that was not served last.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last,
  output logic [1:0] grant
);

  assign grant[0] = valid0 & (~valid1 | last);
  assign grant[1] = valid1 & (~valid0 | ~last);

endmodule

// File: rtl/regalu_seq.sv
// Sequences one instruction at a time from two requesters through an external
// register-file/ALU datapath: IDLE -> EXEC (read/compute) -> WB (write/respond).
module regalu_seq
  import regalu_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_zero,
  output logic               busy,
  output logic [REG_W-1:0]   dp_read_reg1,
  output logic [REG_W-1:0]   dp_read_reg2,
  output logic [REG_W-1:0]   dp_write_reg,
  output logic [OP_W-1:0]    dp_alu_ctrl,
  output logic               dp_reg_write,
  input  logic [DATA_W-1:0]  dp_result,
  input  logic               dp_zero
);

  state_t               state_q, state_d;
  logic                 last_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 id_q;
  logic [DATA_W-1:0]    result_q;
  logic                 zero_q;
  logic [1:0]           grant;
  logic                 idle;
  logic                 accept;

  rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .last   (last_q),
    .grant  (grant)
  );

  assign idle       = (state_q == ST_IDLE);
  assign accept     = idle & (grant != 2'b00);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch at accept; datapath result capture on the EXEC exit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 1'b1;
      instr_q  <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (accept) begin
        instr_q <= grant[1] ? req1_instr : req0_instr;
        id_q    <= grant[1];
        last_q  <= grant[1];
      end
      if (state_q == ST_EXEC) begin
        result_q <= dp_result;
        zero_q   <= dp_zero;
      end
    end
  end

  // All datapath controls decode from registered state only, so a reset
  // removes them combinationally and no input can glitch the write enable.
  always_comb begin
    dp_read_reg1 = '0;
    dp_read_reg2 = '0;
    dp_write_reg = '0;
    dp_alu_ctrl  = '0;
    dp_reg_write = 1'b0;
    if (!idle) begin
      dp_read_reg1 = instr_q[RS1_MSB:RS1_LSB];
      dp_read_reg2 = instr_q[RS2_MSB:RS2_LSB];
      dp_write_reg = instr_q[RD_MSB:RD_LSB];
      dp_alu_ctrl  = instr_q[OP_MSB:OP_LSB];
      dp_reg_write = (state_q == ST_WB) & instr_q[WEN_BIT];
    end
  end

  assign rsp_valid  = (state_q == ST_WB);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = !idle;

endmodule

// File: tb/tb_regalu_seq.sv
// Scoreboard bench for regalu_seq: a cycle-level transaction model predicts
// grants, readies and responses; a monitor checks outputs on the falling edge.
module tb_regalu_seq;

  logic        clk, rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_instr, req1_instr;
  logic        rsp_valid, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_result;
  logic [3:0]  dp_read_reg1, dp_read_reg2, dp_write_reg;
  logic [2:0]  dp_alu_ctrl;
  logic        dp_reg_write;
  logic [31:0] dp_result;
  logic        dp_zero;

  typedef struct {
    logic        id;
    logic [15:0] instr;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_cnt = 0;
  logic        m_last = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        hold_all = 1'b1;
  logic        force_ff = 1'b0;
  logic        prog = 1'b0;
  logic [31:0] prog_res = '0;
  logic        prog_zero = 1'b0;
  logic [31:0] salt = '0;

  regalu_seq #(.DATA_W(32), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_instr   (req0_instr),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_instr   (req1_instr),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .busy         (busy),
    .dp_read_reg1 (dp_read_reg1),
    .dp_read_reg2 (dp_read_reg2),
    .dp_write_reg (dp_write_reg),
    .dp_alu_ctrl  (dp_alu_ctrl),
    .dp_reg_write (dp_reg_write),
    .dp_result    (dp_result),
    .dp_zero      (dp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU: either a programmed value or a scramble of the selects it sees.
  function automatic logic [31:0] mix(input logic [2:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    logic [31:0] f;
    f = {17'd0, op, rd, rs1, rs2};
    return (f * 32'h9E37_79B1) ^ salt;
  endfunction

  assign dp_result = prog ? prog_res : mix(dp_alu_ctrl, dp_write_reg, dp_read_reg1, dp_read_reg2);
  assign dp_zero   = prog ? prog_zero : (dp_result == 32'd0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus plus the reference model's view of that edge.
  task automatic step();
    logic g0, g1;
    exp_t e;
    @(negedge clk);
    if (!v0 && q0.size() > 0 && (hold_all || $urandom_range(1, 0) == 1)) v0 = 1'b1;
    if (!v1 && q1.size() > 0 && (hold_all || $urandom_range(1, 0) == 1)) v1 = 1'b1;
    req0_valid = v0;
    req1_valid = v1;
    req0_instr = v0 ? q0[0] : (force_ff ? 16'hFFFF : 16'($urandom));
    req1_instr = v1 ? q1[0] : (force_ff ? 16'hFFFF : 16'($urandom));
    g0 = (m_cnt == 0) && v0 && (!v1 || m_last);
    g1 = (m_cnt == 0) && v1 && (!v0 || !m_last);
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    @(posedge clk);
    if (m_cnt != 0) begin
      m_cnt--;
    end else if (g0 || g1) begin
      e.id    = g1;
      e.instr = g1 ? q1.pop_front() : q0.pop_front();
      if (g1) v1 = 1'b0;
      else    v0 = 1'b0;
      e.res  = prog ? prog_res : mix(e.instr[15:13], e.instr[11:8], e.instr[7:4], e.instr[3:0]);
      e.zero = prog ? prog_zero : (e.res == 32'd0);
      exp_q.push_back(e);
      m_last = g1;
      m_cnt  = 2;
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_cnt != 0) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d cycles required under %0d", n, max_cyc);
    end
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: cycle-accurate busy/rsp_valid, idle quiescence, in-flight selects.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_cnt == 1));
      if (m_cnt == 0) begin
        chk("idle_dp", 32'({dp_read_reg1, dp_read_reg2, dp_write_reg, dp_alu_ctrl, dp_reg_write}), 32'd0);
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_empty: got busy DUT required a queued expectation");
      end else begin
        e = exp_q[0];
        chk("dp_read_reg1", 32'(dp_read_reg1), 32'(e.instr[7:4]));
        chk("dp_read_reg2", 32'(dp_read_reg2), 32'(e.instr[3:0]));
        chk("dp_write_reg", 32'(dp_write_reg), 32'(e.instr[11:8]));
        chk("dp_alu_ctrl", 32'(dp_alu_ctrl), 32'(e.instr[15:13]));
        chk("dp_reg_write", 32'(dp_reg_write), (m_cnt == 1) ? 32'(e.instr[12]) : 32'd0);
        if (m_cnt == 1) begin
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    salt = $urandom;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_instr = '0;
    req1_instr = '0;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("reset_dp_reg_write", 32'(dp_reg_write), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Both requesters continuously valid: strict alternation, req0 first.
    hold_all = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(16'($urandom));
      q1.push_back(16'($urandom));
    end
    drain(60);

    // Programmed datapath: basic write, then a non-writing zero result.
    prog = 1'b1; prog_res = 32'h5; prog_zero = 1'b0;
    q0.push_back(16'h1312);
    drain(20);
    prog_res = 32'h0; prog_zero = 1'b1;
    q0.push_back(16'h0312);
    drain(20);
    prog = 1'b0;

    // Only req1 requesting, back to back: no bubble between grants.
    q1.push_back(16'($urandom));
    q1.push_back(16'($urandom));
    q1.push_back(16'($urandom));
    drain(30);

    // Requester bus goes to all-ones once the instruction is in flight.
    force_ff = 1'b1;
    q0.push_back(16'h1312);
    drain(20);
    force_ff = 1'b0;

    // Reset while in WB aborts the instruction without write or response.
    q0.push_back(16'hF5A5);
    for (int i = 0; i < 10 && m_cnt != 1; i++) step();
    chk("abort_reached_wb", 32'(m_cnt), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_dp_reg_write", 32'(dp_reg_write), 32'd0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_result", rsp_result, 32'd0);
    chk("abort_rsp_zero", 32'(rsp_zero), 32'd0);
    exp_q.delete();
    m_cnt = 0;
    m_last = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    q0.push_back(16'h1312);
    q1.push_back(16'h2C45);
    drain(30);

    // Randomized traffic with sporadic valids.
    hold_all = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        if ($urandom_range(1, 0) == 1) q1.push_back(16'($urandom));
        else                           q0.push_back(16'($urandom));
      end
      step();
    end
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
